// File: rtl/data_ram_sized_if.sv
// data_ram_sized_if
//   Bundles the MEM-stage request/response signals of data_ram_sized.
//
//   Request  (master -> slave): A, WD, WE, RE, SIZE, SGN
//   Response (slave -> master): RD, RD_VALID, BUSY, MISALIGN, OOR, dbg_state
//
//   Handshake: a request is WE and/or RE high at a rising clk edge. It is
//   accepted on every edge where BUSY is low; there is no other backpressure.
//   While BUSY is high, requests are dropped silently. The response
//   (RD/RD_VALID, MISALIGN, OOR) appears in the cycle after the accepting
//   edge, and each flag is high for that single cycle only.
interface data_ram_sized_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [1:0]  SIZE;
    logic        SGN;
    logic [31:0] RD;
    logic        RD_VALID;
    logic        BUSY;
    logic        MISALIGN;
    logic        OOR;
    logic        dbg_state;   // FSM state: 0 = CLEAR, 1 = IDLE

    modport master (
        output A, WD, WE, RE, SIZE, SGN,
        input  RD, RD_VALID, BUSY, MISALIGN, OOR, dbg_state
    );

    modport slave (
        input  A, WD, WE, RE, SIZE, SGN,
        output RD, RD_VALID, BUSY, MISALIGN, OOR, dbg_state
    );
endinterface

// File: rtl/data_ram_sized.sv
// data_ram_sized
//   Synchronous-read data RAM for the MEM stage. It supports byte, half and
//   word loads and stores, with sign or zero extension on loads. It flags
//   misaligned and out-of-range requests. After reset it runs a clear sweep
//   that zeroes one word per cycle.
//
//   Ports:
//     clk   - single clock, rising edge
//     reset - synchronous, active-low
//     bus   - data_ram_sized_if.slave (request/response bundle)
//     test  - registered mirror of word 0 bits [TEST_W-1:0]
module data_ram_sized #(
    parameter int DEPTH  = 256,
    parameter int TEST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    data_ram_sized_if.slave   bus,
    output logic [TEST_W-1:0] test
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0] rd_q, rd_d;
    logic        rd_valid_q, rd_valid_d;
    logic        mis_q, mis_d;
    logic        oor_q, oor_d;
    logic [TEST_W-1:0] test_q, test_d;

    logic [31:0] ram [DEPTH];

    // Address decode
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_byte, is_half;
    logic          oor, misalign, legal, req;

    assign idx      = bus.A[AW+1:2];
    assign lane     = bus.A[1:0];
    assign is_byte  = (bus.SIZE == 2'b00);
    assign is_half  = (bus.SIZE == 2'b01);
    assign oor      = |bus.A[31:AW+2];
    assign misalign = (is_half && bus.A[0]) || (!is_byte && !is_half && (lane != 2'b00));
    assign legal    = !oor && !misalign;
    assign req      = bus.WE || bus.RE;

    // Store merge: replicate the right-justified data across all lanes,
    // then let the byte enables pick which lanes take it.
    logic [31:0] rd_word, wd_rep, merged, load_val;
    logic [3:0]  be;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign rd_word = ram[idx];

    always_comb begin
        be     = 4'hF;
        wd_rep = bus.WD;
        if (is_byte) begin
            be     = 4'b0001 << lane;
            wd_rep = {4{bus.WD[7:0]}};
        end else if (is_half) begin
            be     = bus.A[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{bus.WD[15:0]}};
        end
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be[k] ? wd_rep[8*k +: 8] : rd_word[8*k +: 8];
        end
    end

    // Load extraction uses the pre-store word (read-before-write)
    assign byte_v = rd_word[{lane, 3'b000} +: 8];
    assign half_v = rd_word[{bus.A[1], 4'b0000} +: 16];

    always_comb begin
        if (is_byte) begin
            load_val = {{24{bus.SGN & byte_v[7]}}, byte_v};
        end else if (is_half) begin
            load_val = {{16{bus.SGN & half_v[15]}}, half_v};
        end else begin
            load_val = rd_word;
        end
    end

    // Memory write port, shared by the clear sweep and stores
    logic          clearing, storing, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    assign clearing  = (state_q == ST_CLEAR) && reset;
    assign storing   = (state_q == ST_IDLE) && reset && bus.WE && legal;
    assign mem_we    = clearing || storing;
    assign mem_addr  = clearing ? ptr_q : idx;
    assign mem_wdata = clearing ? 32'h0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        mis_d      = 1'b0;
        oor_d      = 1'b0;
        test_d     = test_q;

        if (mem_we && (mem_addr == '0)) begin
            test_d = mem_wdata[TEST_W-1:0];
        end

        unique case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    mis_d = misalign;
                    oor_d = oor;
                    if (legal && bus.RE) begin
                        rd_d       = load_val;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rd_q       <= 32'h0;
            rd_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            oor_q      <= 1'b0;
            test_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            mis_q      <= mis_d;
            oor_q      <= oor_d;
            test_q     <= test_d;
        end
    end

    assign bus.RD        = rd_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.BUSY      = (state_q == ST_CLEAR);
    assign bus.MISALIGN  = mis_q;
    assign bus.OOR       = oor_q;
    assign bus.dbg_state = logic'(state_q);
    assign test          = test_q;
endmodule

// File: tb/tb_data_ram_sized.sv
module tb_data_ram_sized;
  logic        clk;
  logic        reset;
  logic [15:0] test;
  int          n_pass;
  int          n_total;
  logic [31:0] exp_q[$];

  data_ram_sized_if bus();

  data_ram_sized #(.DEPTH(256), .TEST_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .test  (test)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request at the next rising edge; returns #1 after that edge.
  task automatic req(input logic we, input logic re, input logic [1:0] size,
                     input logic sgn, input logic [31:0] a, input logic [31:0] wd);
    bus.WE   = we;
    bus.RE   = re;
    bus.SIZE = size;
    bus.SGN  = sgn;
    bus.A    = a;
    bus.WD   = wd;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    bus.RE = 1'b0;
  endtask

  // Counts BUSY-high cycles, bounded.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 1000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(cnt), 32'd256);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    bus.WE = 1'b0; bus.RE = 1'b0; bus.SIZE = 2'b10; bus.SGN = 1'b0;
    bus.A = 32'h0; bus.WD = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.BUSY}, 32'd1);
    chk("rst_rd", bus.RD, 32'h0);
    chk("rst_rdv", {31'b0, bus.RD_VALID}, 32'd0);
    chk("rst_mis", {31'b0, bus.MISALIGN}, 32'd0);
    chk("rst_oor", {31'b0, bus.OOR}, 32'd0);
    chk("rst_test", {16'b0, test}, 32'h0);
    chk("rst_state", {31'b0, bus.dbg_state}, 32'd0);

    reset = 1'b1;
    count_busy("sweep1_len");
    chk("idle_state", {31'b0, bus.dbg_state}, 32'd1);

    // cleared words
    req(0, 1, 2'b10, 0, 32'h000, 0);
    chk("clr0_rd", bus.RD, 32'h0); chk("clr0_v", {31'b0, bus.RD_VALID}, 32'd1);
    req(0, 1, 2'b10, 0, 32'h3FC, 0);
    chk("clr3fc_rd", bus.RD, 32'h0); chk("clr3fc_v", {31'b0, bus.RD_VALID}, 32'd1);
    req(0, 1, 2'b10, 0, 32'h200, 0);
    chk("clr200_rd", bus.RD, 32'h0); chk("clr200_v", {31'b0, bus.RD_VALID}, 32'd1);
    @(posedge clk); #1;
    chk("rdv_pulse", {31'b0, bus.RD_VALID}, 32'd0);

    // word store, byte loads (zero-extended)
    req(1, 0, 2'b10, 0, 32'h10, 32'h12345678);
    chk("st_nov", {31'b0, bus.RD_VALID}, 32'd0);
    exp_q.push_back(32'h78); exp_q.push_back(32'h56);
    exp_q.push_back(32'h34); exp_q.push_back(32'h12);
    for (int i = 0; i < 4; i++) begin
      req(0, 1, 2'b00, 0, 32'h10 + 32'(i), 0);
      chk($sformatf("ldb_%0d", i), bus.RD, exp_q.pop_front());
    end
    req(0, 1, 2'b01, 1, 32'h12, 0);
    chk("ldh12_sx", bus.RD, 32'h00001234);
    req(0, 1, 2'b11, 0, 32'h10, 0);
    chk("ld_rsvd", bus.RD, 32'h12345678);

    // byte store into zeroed word, sign/zero extension
    req(1, 0, 2'b00, 0, 32'h21, 32'hFFFFFF80);
    req(0, 1, 2'b10, 0, 32'h20, 0);
    chk("ldw20", bus.RD, 32'h00008000);
    req(0, 1, 2'b00, 1, 32'h21, 0);
    chk("ldb21_sx", bus.RD, 32'hFFFFFF80);
    req(0, 1, 2'b00, 0, 32'h21, 0);
    chk("ldb21_zx", bus.RD, 32'h00000080);

    // illegal requests
    req(1, 0, 2'b01, 0, 32'h03, 32'hBEEF);
    chk("mis_flag", {31'b0, bus.MISALIGN}, 32'd1);
    chk("mis_nooor", {31'b0, bus.OOR}, 32'd0);
    chk("mis_rdhold", bus.RD, 32'h80);
    @(posedge clk); #1;
    chk("mis_pulse", {31'b0, bus.MISALIGN}, 32'd0);
    req(0, 1, 2'b10, 0, 32'h400, 0);
    chk("oor_flag", {31'b0, bus.OOR}, 32'd1);
    chk("oor_nomis", {31'b0, bus.MISALIGN}, 32'd0);
    chk("oor_nov", {31'b0, bus.RD_VALID}, 32'd0);
    chk("oor_rdhold", bus.RD, 32'h80);
    req(0, 1, 2'b10, 0, 32'h402, 0);
    chk("both_oor", {31'b0, bus.OOR}, 32'd1);
    chk("both_mis", {31'b0, bus.MISALIGN}, 32'd1);
    req(0, 1, 2'b10, 0, 32'h0, 0);
    chk("mis_unchanged", bus.RD, 32'h0);
    chk("mis_test", {16'b0, test}, 32'h0);

    // negative half
    req(1, 0, 2'b01, 0, 32'h2A, 32'h00008001);
    req(0, 1, 2'b10, 0, 32'h28, 0);
    chk("ldw28", bus.RD, 32'h80010000);
    req(0, 1, 2'b01, 1, 32'h2A, 0);
    chk("ldh2a_sx", bus.RD, 32'hFFFF8001);

    // word 0 mirror and read-before-write
    req(1, 0, 2'b10, 0, 32'h0, 32'hAAAA5555);
    chk("test_5555", {16'b0, test}, 32'h5555);
    req(1, 1, 2'b10, 0, 32'h0, 32'h1);
    chk("rbw_rd", bus.RD, 32'hAAAA5555);
    chk("rbw_v", {31'b0, bus.RD_VALID}, 32'd1);
    chk("rbw_test", {16'b0, test}, 32'h1);
    req(0, 1, 2'b10, 0, 32'h0, 0);
    chk("rbw_after", bus.RD, 32'h1);

    // reset during sweep
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    req(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    req(0, 1, 2'b10, 0, 32'h10, 0);
    chk("busy_nov", {31'b0, bus.RD_VALID}, 32'd0);
    repeat (48) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst2_busy", {31'b0, bus.BUSY}, 32'd1);
    chk("rst2_test", {16'b0, test}, 32'h0);
    reset = 1'b1;
    count_busy("sweep2_len");
    req(0, 1, 2'b10, 0, 32'h10, 0);
    chk("busy_store_lost", bus.RD, 32'h0);
    chk("final_v", {31'b0, bus.RD_VALID}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_ram_sized.md
# data_ram_sized

Parametrised successor to the MIPS data memory. It is a synchronous-read data RAM with byte, halfword and word loads/stores and sign/zero extension on loads. It detects misaligned and out-of-range accesses, and after reset it runs a hardware clear sweep that zeroes one word per cycle. It sits on the processor's MEM stage: the ALU result drives `A`, rt drives `WD`, and `RD` feeds write-back.

## Interface
- `DEPTH`, 256: number of 32-bit words. Must be a power of 2 and ≥ 4.
- `TEST_W`, 16: width of the debug mirror `test`; range 1–32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `A` input 32: byte address.
- `WD` input 32: store data, right-justified for sub-word stores.
- `WE` input 1: store request.
- `RE` input 1: load request.
- `SIZE` input 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `SGN` input 1: 1 = sign-extend sub-word loads, 0 = zero-extend.
- `RD` output 32: load data, registered.
- `RD_VALID` output 1: one-cycle pulse when `RD` carries fresh load data.
- `BUSY` output 1: clear sweep in progress; requests are ignored while high.
- `MISALIGN` output 1: one-cycle pulse for a misaligned request.
- `OOR` output 1: one-cycle pulse for an out-of-range request.
- `test` output TEST_W: registered mirror of word 0, bits [TEST_W-1:0].

## Operation
- Reset (`reset`=0 at an edge):
  - State goes to CLEAR and the clear pointer to 0.
  - `RD`=0, `RD_VALID`=0, `MISALIGN`=0, `OOR`=0, `test`=0, `BUSY`=1.
- FSM has two states, CLEAR and IDLE.
  - CLEAR: write 0 to `ram[ptr]`, then increment `ptr`. The cycle that writes `ptr`=DEPTH-1 moves the FSM to IDLE. `WE`/`RE` are ignored (no write, no pulses).
  - IDLE: serve requests. The FSM never returns to CLEAR except through reset.
  - Reset asserted mid-sweep restarts the sweep at word 0.
- Address decode:
  - word index = `A[log2(DEPTH)+1:2]`; lane = `A[1:0]`.
  - OOR when any bit of `A[31:log2(DEPTH)+2]` is 1.
  - MISALIGN when (half and `A[0]`=1) or (word/reserved and `A[1:0]`≠0).
  - An access that is both raises both flags.
- Lane order is little-endian: lane k = bits [8k+7:8k].
- Store (`WE`=1, legal):
  - byte: `WD[7:0]` into lane `A[1:0]`.
  - half: `WD[15:0]` into lanes 2·`A[1]` and 2·`A[1]`+1.
  - word: full word.
  - Other lanes are unchanged.
- Load (`RE`=1, legal):
  - Extract the lane(s) from the same decode as stores.
  - Extend to 32 bits per `SGN`; `SGN` is ignored for words.
- Illegal request (either flag set):
  - No memory write; `RD` keeps its previous value; `RD_VALID` stays 0.
  - The flag(s) pulse.
  - `WE` and `RE` both low means no request and no flags.
- `WE` and `RE` together at the same address: the load returns pre-store data (read-before-write), and the store still takes effect.
- `RD` holds its last loaded value until the next legal load.
- `test` updates whenever word 0 is written, by a store or by the sweep.

## Timing
- `BUSY` is high during reset and for exactly DEPTH cycles after the first edge with `reset`=1; it falls in the cycle the FSM enters IDLE.
- Load latency is 1: `RE` sampled at edge N gives `RD`/`RD_VALID` valid after edge N (cycle N+1). Back-to-back loads run at one per cycle.
- Stores commit at the sampling edge; a load in the next cycle sees the new data.
- `MISALIGN`/`OOR` assert in cycle N+1 for a request at edge N, aligned with where `RD_VALID` would be.
- `test` reflects a store to word 0 in cycle N+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then release with DEPTH=256: `BUSY`=1 for 256 cycles then 0. Word loads from 0x000, 0x3FC and 0x200 return 0 with `RD_VALID` pulsing one cycle after each `RE`.
- Word store 0x12345678 @0x10, then byte loads @0x10..0x13 with `SGN`=0: `RD` = 0x78, 0x56, 0x34, 0x12. Half load @0x12 `SGN`=1 → 0x00001234.
- Byte store 0x80 @0x21 over word 0 at 0x20: word load @0x20 → 0x00008000. Byte load @0x21 with `SGN`=1 → 0xFFFFFF80, with `SGN`=0 → 0x00000080.
- Half store @0x03: `MISALIGN` pulses, memory unchanged. Word load @0x400: `OOR` pulses, `RD_VALID`=0, `RD` holds its prior value.
- Word store 0xAAAA5555 @0x0: `test`=0x5555 next cycle. Simultaneous `WE`+`RE` @0x0 with `WD`=0x1: `RD`=0xAAAA5555, and the following load returns 0x1.
- Drop `reset` at sweep cycle 100, release: `BUSY` high for a full 256 more cycles. Earlier stores issued during `BUSY` have no effect.
